fetch_sequencer: RTL and testbench

Control block for the Y86-64 SEQ fetch stage. Owns the program counter and sequences instruction fetch. It presents `pc` to the fetch stage and receives the decoded `icode`/`ifun`/`valC`/`valP` in the same cycle. It then selects the next PC, waiting where needed for a branch condition from execute or a return address from memory. It also tracks processor status: AOK, HLT, ADR or INS.

---
 rtl/fetch_sequencer_if.sv | 25 ++
 rtl/fetch_sequencer.sv | 135 +++++++++++++
 tb/tb_fetch_sequencer.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_sequencer_if.sv
// Fetch/execute/memory handshake bundle between the SEQ fetch sequencer and the datapath.
// master = sequencer (drives pc/fetch_valid), slave = datapath side.
interface fetch_sequencer_if;
  logic [63:0] pc;
  logic        fetch_valid;
  logic        stall;
  logic [3:0]  icode;
  logic [3:0]  ifun;
  logic [63:0] valC;
  logic [63:0] valP;
  logic        cnd;
  logic        cnd_valid;
  logic [63:0] valM;
  logic        valm_valid;

  modport master (
    output pc, fetch_valid,
    input  stall, icode, ifun, valC, valP, cnd, cnd_valid, valM, valm_valid
  );

  modport slave (
    input  pc, fetch_valid,
    output stall, icode, ifun, valC, valP, cnd, cnd_valid, valM, valm_valid
  );
endinterface

// File: rtl/fetch_sequencer.sv
// Y86-64 SEQ PC owner/fetch sequencer: one decision per FETCH cycle, all outputs registered.
// Latency 1 cycle per straight-line instruction; stall holds pc/state, jxx/ret wait for cnd_valid/valm_valid.
module fetch_sequencer #(
  parameter int IMEM_BYTES = 1024
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start,
  input  logic [63:0]               start_pc,
  fetch_sequencer_if.master         bus,
  output logic [2:0]                stat,
  output logic                      busy,
  output logic [31:0]               retired
);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_FETCH    = 3'd1;
  localparam logic [2:0] S_WAIT_CND = 3'd2;
  localparam logic [2:0] S_WAIT_RET = 3'd3;
  localparam logic [2:0] S_HALT     = 3'd4;
  localparam logic [2:0] S_ERR      = 3'd5;

  localparam logic [2:0] STAT_AOK = 3'd1;
  localparam logic [2:0] STAT_HLT = 3'd2;
  localparam logic [2:0] STAT_ADR = 3'd3;
  localparam logic [2:0] STAT_INS = 3'd4;

  localparam logic [63:0] PC_MAX = 64'(IMEM_BYTES - 10);

  logic [2:0]  state, state_n;
  logic [63:0] pc_q, pc_n;
  logic [2:0]  stat_n;
  logic [63:0] lat_valc, lat_valc_n;
  logic [63:0] lat_valp, lat_valp_n;
  logic        fetch_valid_q;
  logic        retire;

  always_comb begin
    state_n    = state;
    pc_n       = pc_q;
    stat_n     = stat;
    lat_valc_n = lat_valc;
    lat_valp_n = lat_valp;
    retire     = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          pc_n    = start_pc;
          state_n = S_FETCH;
        end
      end
      S_FETCH: begin
        // Range check wins over stall: an illegal pc can never be fetched.
        if (pc_q > PC_MAX) begin
          stat_n  = STAT_ADR;
          state_n = S_ERR;
        end else if (!bus.stall) begin
          case (bus.icode)
            4'h0: begin
              stat_n  = STAT_HLT;
              retire  = 1'b1;
              state_n = S_HALT;
            end
            4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'hA, 4'hB: begin
              pc_n   = bus.valP;
              retire = 1'b1;
            end
            4'h7: begin
              if (bus.ifun == 4'h0) begin
                pc_n   = bus.valC;
                retire = 1'b1;
              end else if (bus.ifun <= 4'h6) begin
                lat_valc_n = bus.valC;
                lat_valp_n = bus.valP;
                state_n    = S_WAIT_CND;
              end else begin
                stat_n  = STAT_INS;
                state_n = S_ERR;
              end
            end
            4'h8: begin
              pc_n   = bus.valC;
              retire = 1'b1;
            end
            4'h9: state_n = S_WAIT_RET;
            default: begin
              stat_n  = STAT_INS;
              state_n = S_ERR;
            end
          endcase
        end
      end
      S_WAIT_CND: begin
        if (bus.cnd_valid) begin
          pc_n    = bus.cnd ? lat_valc : lat_valp;
          retire  = 1'b1;
          state_n = S_FETCH;
        end
      end
      S_WAIT_RET: begin
        if (bus.valm_valid) begin
          pc_n    = bus.valM;
          retire  = 1'b1;
          state_n = S_FETCH;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= S_IDLE;
      pc_q          <= 64'd0;
      stat          <= STAT_AOK;
      lat_valc      <= 64'd0;
      lat_valp      <= 64'd0;
      fetch_valid_q <= 1'b0;
      retired       <= 32'd0;
    end else begin
      state         <= state_n;
      pc_q          <= pc_n;
      stat          <= stat_n;
      lat_valc      <= lat_valc_n;
      lat_valp      <= lat_valp_n;
      fetch_valid_q <= (state_n == S_FETCH) && (pc_n <= PC_MAX);
      retired       <= retired + 32'(retire);
    end
  end

  assign bus.pc          = pc_q;
  assign bus.fetch_valid = fetch_valid_q;
  assign busy            = (state == S_FETCH) || (state == S_WAIT_CND) || (state == S_WAIT_RET);

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer: scenario tasks with hand-computed expectations.
module tb_fetch_sequencer;

  logic        clk;
  logic        reset;
  logic        start;
  logic [63:0] start_pc;
  logic [2:0]  stat;
  logic        busy;
  logic [31:0] retired;

  int checks;
  int passes;

  fetch_sequencer_if bus ();

  fetch_sequencer #(.IMEM_BYTES(1024)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .start_pc (start_pc),
    .bus      (bus),
    .stat     (stat),
    .busy     (busy),
    .retired  (retired)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change and outputs are sampled 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    start          = 1'b0;
    start_pc       = 64'd0;
    bus.stall      = 1'b0;
    bus.icode      = 4'h1;
    bus.ifun       = 4'h0;
    bus.valC       = 64'd0;
    bus.valP       = 64'd0;
    bus.cnd        = 1'b0;
    bus.cnd_valid  = 1'b0;
    bus.valM       = 64'd0;
    bus.valm_valid = 1'b0;
  endtask

  task automatic do_reset();
    clear_inputs();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic do_start(input logic [63:0] addr);
    start    = 1'b1;
    start_pc = addr;
    tick();
    start    = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (bus.pc !== 64'd0) $display("FAIL reset_pc got %0h want 0", bus.pc); else passes++;
    checks++; if (bus.fetch_valid !== 1'b0) $display("FAIL reset_fetch_valid got %b want 0", bus.fetch_valid); else passes++;
    checks++; if (stat !== 3'd1) $display("FAIL reset_stat got %0d want 1", stat); else passes++;
    checks++; if (busy !== 1'b0) $display("FAIL reset_busy got %b want 0", busy); else passes++;
    checks++; if (retired !== 32'd0) $display("FAIL reset_retired got %0d want 0", retired); else passes++;
  endtask

  task automatic test_straight_line();
    do_reset();
    do_start(64'h10);
    checks++; if (bus.pc !== 64'h10) $display("FAIL sl_start_pc got %0h want 10", bus.pc); else passes++;
    checks++; if (bus.fetch_valid !== 1'b1) $display("FAIL sl_start_fv got %b want 1", bus.fetch_valid); else passes++;
    checks++; if (busy !== 1'b1) $display("FAIL sl_busy got %b want 1", busy); else passes++;
    bus.icode = 4'h1; bus.valP = 64'h1A;
    tick();
    checks++; if (bus.pc !== 64'h1A) $display("FAIL sl_nop_pc got %0h want 1a", bus.pc); else passes++;
    checks++; if (retired !== 32'd1) $display("FAIL sl_nop_ret got %0d want 1", retired); else passes++;
    bus.icode = 4'h3; bus.valP = 64'h24;
    tick();
    checks++; if (bus.pc !== 64'h24) $display("FAIL sl_irmov_pc got %0h want 24", bus.pc); else passes++;
    bus.icode = 4'h0; bus.valP = 64'h26;
    tick();
    checks++; if (stat !== 3'd2) $display("FAIL sl_halt_stat got %0d want 2", stat); else passes++;
    checks++; if (retired !== 32'd3) $display("FAIL sl_halt_ret got %0d want 3", retired); else passes++;
    checks++; if (busy !== 1'b0) $display("FAIL sl_halt_busy got %b want 0", busy); else passes++;
    checks++; if (bus.pc !== 64'h24) $display("FAIL sl_halt_pc got %0h want 24", bus.pc); else passes++;
    checks++; if (bus.fetch_valid !== 1'b0) $display("FAIL sl_halt_fv got %b want 0", bus.fetch_valid); else passes++;
    // HALT must ignore every strobe.
    start = 1'b1; start_pc = 64'h200; bus.icode = 4'h1; bus.valP = 64'h300;
    bus.cnd_valid = 1'b1; bus.cnd = 1'b1; bus.valm_valid = 1'b1; bus.valM = 64'h400;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++; if (bus.pc !== 64'h24 || stat !== 3'd2 || retired !== 32'd3 || busy !== 1'b0)
        $display("FAIL sl_hold cycle %0d got pc=%0h stat=%0d ret=%0d busy=%b want 24/2/3/0", i, bus.pc, stat, retired, busy);
      else passes++;
    end
    clear_inputs();
  endtask

  task automatic test_cond_jump(input logic cnd_val, input logic [63:0] exp_pc);
    do_reset();
    do_start(64'h20);
    bus.icode = 4'h7; bus.ifun = 4'h1; bus.valC = 64'h80; bus.valP = 64'h2A;
    tick();
    bus.icode = 4'h1; bus.valC = 64'h999; bus.valP = 64'h777;
    for (int i = 0; i < 2; i++) begin
      checks++; if (bus.fetch_valid !== 1'b0 || busy !== 1'b1 || retired !== 32'd0)
        $display("FAIL jxx_wait cycle %0d got fv=%b busy=%b ret=%0d want 0/1/0", i, bus.fetch_valid, busy, retired);
      else passes++;
      tick();
    end
    bus.cnd_valid = 1'b1; bus.cnd = cnd_val;
    tick();
    bus.cnd_valid = 1'b0;
    checks++; if (bus.pc !== exp_pc) $display("FAIL jxx_pc cnd=%b got %0h want %0h", cnd_val, bus.pc, exp_pc); else passes++;
    checks++; if (bus.fetch_valid !== 1'b1) $display("FAIL jxx_fv got %b want 1", bus.fetch_valid); else passes++;
    checks++; if (retired !== 32'd1) $display("FAIL jxx_ret got %0d want 1", retired); else passes++;
  endtask

  task automatic test_call_ret();
    do_reset();
    do_start(64'h40);
    bus.icode = 4'h8; bus.valC = 64'h100; bus.valP = 64'h49;
    tick();
    checks++; if (bus.pc !== 64'h100) $display("FAIL call_pc got %0h want 100", bus.pc); else passes++;
    bus.icode = 4'h9; bus.valP = 64'h101;
    tick();
    checks++; if (bus.fetch_valid !== 1'b0) $display("FAIL ret_wait_fv got %b want 0", bus.fetch_valid); else passes++;
    bus.cnd_valid = 1'b1; bus.cnd = 1'b1;
    tick();
    bus.cnd_valid = 1'b0;
    checks++; if (bus.pc !== 64'h100 || retired !== 32'd1) $display("FAIL ret_stray_cnd got pc=%0h ret=%0d want 100/1", bus.pc, retired); else passes++;
    bus.valm_valid = 1'b1; bus.valM = 64'h3C;
    tick();
    bus.valm_valid = 1'b0;
    checks++; if (bus.pc !== 64'h3C) $display("FAIL ret_pc got %0h want 3c", bus.pc); else passes++;
    checks++; if (retired !== 32'd2) $display("FAIL ret_retired got %0d want 2", retired); else passes++;
    checks++; if (bus.fetch_valid !== 1'b1) $display("FAIL ret_fv got %b want 1", bus.fetch_valid); else passes++;
  endtask

  task automatic test_errors();
    do_reset();
    do_start(64'h10);
    bus.icode = 4'hC;
    tick();
    checks++; if (stat !== 3'd4) $display("FAIL ins_icode_stat got %0d want 4", stat); else passes++;
    checks++; if (retired !== 32'd0) $display("FAIL ins_icode_ret got %0d want 0", retired); else passes++;
    checks++; if (busy !== 1'b0 || bus.fetch_valid !== 1'b0) $display("FAIL ins_icode_idle got busy=%b fv=%b want 0/0", busy, bus.fetch_valid); else passes++;

    do_reset();
    do_start(64'h10);
    bus.icode = 4'h7; bus.ifun = 4'h7;
    tick();
    checks++; if (stat !== 3'd4) $display("FAIL ins_ifun_stat got %0d want 4", stat); else passes++;

    do_reset();
    do_start(64'd1014);
    checks++; if (bus.fetch_valid !== 1'b1) $display("FAIL adr_edge_fv got %b want 1", bus.fetch_valid); else passes++;

    do_reset();
    do_start(64'd1015);
    checks++; if (bus.fetch_valid !== 1'b0 || busy !== 1'b1) $display("FAIL adr_fetch got fv=%b busy=%b want 0/1", bus.fetch_valid, busy); else passes++;
    bus.icode = 4'h1; bus.valP = 64'h20; bus.stall = 1'b1;
    tick();
    bus.stall = 1'b0;
    checks++; if (stat !== 3'd3) $display("FAIL adr_stat got %0d want 3", stat); else passes++;
    checks++; if (retired !== 32'd0 || bus.pc !== 64'd1015) $display("FAIL adr_hold got ret=%0d pc=%0d want 0/1015", retired, bus.pc); else passes++;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (bus.fetch_valid !== 1'b0) $display("FAIL adr_fv cycle %0d got %b want 0", i, bus.fetch_valid); else passes++;
    end
  endtask

  task automatic test_stall();
    do_reset();
    do_start(64'h10);
    bus.icode = 4'h1; bus.valP = 64'h1A; bus.stall = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++; if (bus.pc !== 64'h10 || retired !== 32'd0 || bus.fetch_valid !== 1'b1)
        $display("FAIL stall cycle %0d got pc=%0h ret=%0d fv=%b want 10/0/1", i, bus.pc, retired, bus.fetch_valid);
      else passes++;
    end
    bus.stall = 1'b0;
    tick();
    checks++; if (bus.pc !== 64'h1A || retired !== 32'd1) $display("FAIL stall_release got pc=%0h ret=%0d want 1a/1", bus.pc, retired); else passes++;
  endtask

  task automatic test_reset_mid_wait();
    do_reset();
    do_start(64'h10);
    bus.icode = 4'h8; bus.valC = 64'h50;
    tick();
    bus.icode = 4'h9;
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checks++; if (bus.pc !== 64'd0 || stat !== 3'd1) $display("FAIL rst_wait got pc=%0h stat=%0d want 0/1", bus.pc, stat); else passes++;
    checks++; if (retired !== 32'd0 || busy !== 1'b0) $display("FAIL rst_wait_cnt got ret=%0d busy=%b want 0/0", retired, busy); else passes++;
    bus.valm_valid = 1'b1; bus.valM = 64'h3C;
    tick();
    bus.valm_valid = 1'b0;
    checks++; if (bus.pc !== 64'd0 || busy !== 1'b0 || retired !== 32'd0)
      $display("FAIL rst_stray_valm got pc=%0h busy=%b ret=%0d want 0/0/0", bus.pc, busy, retired);
    else passes++;
  endtask

  initial begin
    checks = 0;
    passes = 0;
    reset  = 1'b1;
    clear_inputs();
    test_reset();
    test_straight_line();
    test_cond_jump(1'b1, 64'h80);
    test_cond_jump(1'b0, 64'h2A);
    test_call_ret();
    test_errors();
    test_stall();
    test_reset_mid_wait();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
